// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO read arbiter: flit type encoding, arbiter FSM states
// and the position of the type field inside a flit.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HEAD   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int flit_type_msb(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int flit_type_lsb(input int flit_w);
    return flit_w - 2;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester at or above ptr wins, wrapping
// modulo NUM_IN. Zero latency, no backpressure; gnt_oh is all-zero when nothing requests.
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt_oh,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic             w_found;
  int               w_j;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_j     = 0;
    w_cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= NUM_IN) w_j = w_j - NUM_IN;
      w_cand = IDX_W'(w_j);
      if (!w_found && req[w_cand]) begin
        w_found         = 1'b1;
        gnt_oh[w_cand]  = 1'b1;
        gnt_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Packet-atomic round-robin scheduler over NUM_IN FWFT FIFO read ports; 1-cycle RINC->OUT_VALID,
// RINC held low while the output register is full and stalled. ARB_WATCHDOG_EN adds a stall watchdog.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int FLIT_W  = 34,
  parameter int IDX_W   = $clog2(NUM_IN),
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_IN-1:0]        REMPTY,
  input  logic [NUM_IN*FLIT_W-1:0] RDATA,
  output logic [NUM_IN-1:0]        RINC,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [FLIT_W-1:0]        OUT_DATA,
  output logic [IDX_W-1:0]         OUT_SRC,
  output logic                     LOCKED,
  output logic                     ERR
);

  localparam int TMSB = flit_type_msb(FLIT_W);
  localparam int TLSB = flit_type_lsb(FLIT_W);

  arb_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]  r_gnt, w_gnt_nxt;
  logic              r_out_vld;
  logic [FLIT_W-1:0] r_out_dat;
  logic [IDX_W-1:0]  r_out_src;

  logic [NUM_IN-1:0] w_pick_oh;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_slot_free;
  logic              w_pop;
  logic [IDX_W-1:0]  w_pop_idx;
  logic [FLIT_W-1:0] w_flit;
  flit_type_e        w_ftype;
  logic              w_timeout;
  logic [FLIT_W-1:0] w_port_dat [NUM_IN];

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_IN - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_port
    assign w_port_dat[gi] = RDATA[gi*FLIT_W +: FLIT_W];
  end

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req     (~REMPTY),
    .ptr     (r_rr_ptr),
    .gnt_oh  (w_pick_oh),
    .gnt_idx (w_pick_idx)
  );

  assign w_slot_free = !r_out_vld || OUT_READY;

  // Pop gated by reset so no flit is drawn out of a FIFO only to be dropped.
  always_comb begin
    w_pop     = 1'b0;
    w_pop_idx = r_gnt;
    if (r_state == ST_IDLE) begin
      w_pop_idx = w_pick_idx;
      w_pop     = (|w_pick_oh) && w_slot_free && !RST;
    end else begin
      w_pop     = !REMPTY[r_gnt] && w_slot_free && !RST;
    end
  end

  assign w_flit  = w_port_dat[w_pop_idx];
  assign w_ftype = flit_type_e'(w_flit[TMSB:TLSB]);
  assign RINC    = w_pop ? (NUM_IN'(1) << w_pop_idx) : '0;

  // BODY/TAIL seen while idle fall through as single-flit packets: no lock taken.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_gnt_nxt    = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_rr_ptr_nxt = wrap_inc(w_pop_idx);
          if (w_ftype == HEAD) begin
            w_state_nxt = ST_LOCKED;
            w_gnt_nxt   = w_pop_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (w_pop && (w_ftype == TAIL || w_ftype == SINGLE)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = wrap_inc(r_gnt);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_src <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_gnt    <= w_gnt_nxt;
      if (w_pop) begin
        r_out_vld <= 1'b1;
        r_out_dat <= w_flit;
        r_out_src <= w_pop_idx;
      end else if (OUT_READY) begin
        r_out_vld <= 1'b0;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err;
  logic             w_stall;

  assign w_stall   = (r_state == ST_LOCKED) && REMPTY[r_gnt];
  assign w_timeout = w_stall && (r_stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else if (w_pop) begin
      r_stall_cnt <= '0;
    end else if (w_timeout) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b1;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ERR = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
  assign ERR              = 1'b0;
`endif

  assign OUT_VALID = r_out_vld;
  assign OUT_DATA  = r_out_dat;
  assign OUT_SRC   = r_out_src;
  assign LOCKED    = (r_state == ST_LOCKED);

endmodule
